mem_access_arbiter: RTL and testbench



---
 rtl/mem_access_arbiter.sv | 101 ++++++++++
 tb/tb_mem_access_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the 16x16 data memory controller between the pipeline
// MEM stage (port A, priority) and the debug/program loader (port B).
module mem_access_arbiter #(
    parameter logic [15:0] SCRATCH_ADDR = 16'h000F,
    parameter int unsigned MAX_WAIT     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] mem_write_addr,
    output logic [15:0] mem_read_addr,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [1:0]  state;
    logic        cap_we;
    logic        cap_b;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;
    logic [15:0] rdata_q;
    logic [3:0]  wait_cnt;

    logic b_forced;
    logic a_win;
    logic b_win;
    logic write_live;

    // B is forced through once A has taken MAX_WAIT grants while B was waiting.
    assign b_forced = b_req && (wait_cnt == WAIT_LIMIT);
    assign a_win    = a_req && !b_forced;
    assign b_win    = b_req && !a_win;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_b     <= 1'b0;
            cap_addr  <= 16'h0000;
            cap_wdata <= 16'h0000;
            rdata_q   <= 16'h0000;
            wait_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_win || b_win) begin
                        cap_b     <= b_win;
                        cap_we    <= b_win ? b_we    : a_we;
                        cap_addr  <= b_win ? b_addr  : a_addr;
                        cap_wdata <= b_win ? b_wdata : a_wdata;
                        state     <= ISSUE;
                    end
                    if (b_win || !b_req)
                        wait_cnt <= 4'd0;
                    else if (a_win && (wait_cnt != WAIT_LIMIT))
                        wait_cnt <= wait_cnt + 4'd1;
                end
                ISSUE: state <= cap_we ? IDLE : RESP;
                RESP: begin
                    rdata_q <= mem_read_data;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes aimed at the scratch word are granted but never reach memory.
    assign write_live = (state == ISSUE) && cap_we &&
                        (cap_addr[3:0] != SCRATCH_ADDR[3:0]);

    assign a_gnt    = (state == ISSUE) && !cap_b;
    assign b_gnt    = (state == ISSUE) &&  cap_b;
    assign a_rvalid = (state == RESP)  && !cap_b;
    assign b_rvalid = (state == RESP)  &&  cap_b;
    assign rdata    = (state == RESP) ? mem_read_data : rdata_q;

    assign mem_write_addr = write_live ? cap_addr  : SCRATCH_ADDR;
    assign mem_write_data = write_live ? cap_wdata : 16'h0000;
    // Read address simply follows the last captured address; it is what the
    // controller samples at the end of ISSUE and stays stable afterwards.
    assign mem_read_addr  = cap_addr;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_mem_access_arbiter;

    localparam logic [15:0] SCRATCH = 16'h000F;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [15:0] rdata, mem_write_addr, mem_read_addr, mem_write_data;
    logic [15:0] mem_read_data = 16'h0000;
    logic [15:0] mem [16] = '{default: 16'h0000};

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_arbiter #(.SCRATCH_ADDR(SCRATCH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory controller: write every clock, registered read.
    always @(posedge clk) begin
        mem[mem_write_addr[3:0]] <= mem_write_data;
        mem_read_data <= mem[mem_read_addr[3:0]];
    end

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid});
        end
        n_tests++;
        if (rdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rdata: got %h want 0000", rdata);
        end
        n_tests++;
        if (mem_write_addr !== 16'h000F || mem_write_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_wpath: got %h/%h want 000f/0000", mem_write_addr, mem_write_data);
        end
        n_tests++;
        if (mem_read_addr !== 16'h0000) begin
            n_fail++; $display("FAIL reset_raddr: got %h want 0000", mem_read_addr);
        end
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_write_addr !== SCRATCH || mem_write_data !== 16'h0) begin
                n_fail++;
                $display("FAIL idle_parked: gnt %b%b wpath %h/%h want 00 000f/0000",
                         a_gnt, b_gnt, mem_write_addr, mem_write_data);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0003; a_wdata = 16'hBEEF;
        @(negedge clk);
        n_tests++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_write_addr !== 16'h0003 || mem_write_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL a_write_issue: gnt %b%b wpath %h/%h want 10 0003/beef",
                     a_gnt, b_gnt, mem_write_addr, mem_write_data);
        end
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_gnt !== 1'b0 || mem_write_addr !== SCRATCH || mem_write_data !== 16'h0) begin
            n_fail++; $display("FAIL after_write_parked: gnt %b wpath %h/%h", a_gnt, mem_write_addr, mem_write_data);
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0003;
        @(negedge clk);
        n_tests++;
        if (a_gnt !== 1'b1 || mem_read_addr !== 16'h0003 || mem_write_addr !== SCRATCH) begin
            n_fail++;
            $display("FAIL a_read_issue: gnt %b raddr %h waddr %h want 1 0003 000f", a_gnt, mem_read_addr, mem_write_addr);
        end
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL a_read_resp: rvalid %b%b rdata %h want 10 beef", a_rvalid, b_rvalid, rdata);
        end
        @(negedge clk);
        n_tests++;
        if (a_rvalid !== 1'b0 || rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL rdata_hold: rvalid %b rdata %h want 0 beef", a_rvalid, rdata);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0001;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0002; b_wdata = 16'h1234;
        @(negedge clk);
        n_tests++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++; $display("FAIL simul_a_first: gnt %b%b want 10", a_gnt, b_gnt);
        end
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_rvalid !== 1'b1 || rdata !== 16'h0000 || b_gnt !== 1'b0) begin
            n_fail++; $display("FAIL simul_a_resp: rvalid %b rdata %h bgnt %b want 1 0000 0", a_rvalid, rdata, b_gnt);
        end
        @(negedge clk);
        n_tests++;
        if (b_gnt !== 1'b0) begin
            n_fail++; $display("FAIL simul_b_idle: b_gnt %b want 0", b_gnt);
        end
        @(negedge clk);
        n_tests++;
        if (b_gnt !== 1'b1 || mem_write_addr !== 16'h0002 || mem_write_data !== 16'h1234) begin
            n_fail++; $display("FAIL simul_b_write: gnt %b wpath %h/%h want 1 0002/1234", b_gnt, mem_write_addr, mem_write_data);
        end
        b_req = 1'b0;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0002;
        @(negedge clk);
        n_tests++;
        if (b_gnt !== 1'b1) begin
            n_fail++; $display("FAIL simul_b_read_gnt: got %b want 1", b_gnt);
        end
        b_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || rdata !== 16'h1234) begin
            n_fail++; $display("FAIL simul_b_read: rvalid %b%b rdata %h want 01 1234", a_rvalid, b_rvalid, rdata);
        end
    endtask

    task automatic test_starvation();
        int na = 0;
        int rounds = 0;
        logic raise_b = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0005; a_wdata = 16'h5A5A;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0005;
        for (int c = 0; c < 80 && rounds < 2; c++) begin
            @(negedge clk);
            if (raise_b) begin b_req = 1'b1; raise_b = 1'b0; end
            if (a_gnt === 1'b1) na++;
            if (b_gnt === 1'b1) begin
                n_tests++;
                if (na != MAXW) begin
                    n_fail++; $display("FAIL starvation_a_grants round %0d: got %0d want %0d", rounds, na, MAXW);
                end
                na = 0;
                rounds++;
                b_req = 1'b0;
                raise_b = (rounds < 2);
            end
        end
        n_tests++;
        if (rounds != 2) begin
            n_fail++; $display("FAIL starvation_timeout: got %0d b grants want 2", rounds);
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scratch();
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h001F; b_wdata = 16'hAAAA;
        @(negedge clk);
        n_tests++;
        if (b_gnt !== 1'b1 || mem_write_addr !== SCRATCH || mem_write_data !== 16'h0000) begin
            n_fail++; $display("FAIL scratch_write: gnt %b wpath %h/%h want 1 000f/0000", b_gnt, mem_write_addr, mem_write_data);
        end
        b_req = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h000F;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_rvalid !== 1'b1 || rdata !== 16'h0000) begin
            n_fail++; $display("FAIL scratch_read: rvalid %b rdata %h want 1 0000", a_rvalid, rdata);
        end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0003;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_tests++;
        if (a_rvalid !== 1'b0 || rdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_resp_abort: rvalid %b rdata %h want 0 0000", a_rvalid, rdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_resp_idle: got %b want 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid});
        end
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0003;
        @(negedge clk);
        n_tests++;
        if (a_gnt !== 1'b1) begin
            n_fail++; $display("FAIL reset_resp_regnt: got %b want 1", a_gnt);
        end
        a_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL reset_resp_reread: rvalid %b rdata %h want 1 beef", a_rvalid, rdata);
        end
    endtask

    // Transaction model: the arbiter is free from cycle free_at; a granted
    // access shows gnt one cycle later and a read returns data two cycles later.
    task automatic test_random();
        logic [15:0] rm [16];
        logic        e_ag [4], e_bg [4], e_ar [4], e_br [4], e_ron [4];
        logic [15:0] e_wa [4], e_wd [4], e_ra [4], e_rv [4];
        logic [15:0] m_rdata, exp_rd, addr, wd;
        logic        pick_a, pick_b, we;
        int          free_at, wcnt, s, t, r;
        for (int i = 0; i < 16; i++) rm[i] = 16'h0000;
        rm[2] = 16'h1234; rm[3] = 16'hBEEF; rm[5] = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
            e_ag[i] = 0; e_bg[i] = 0; e_ar[i] = 0; e_br[i] = 0; e_ron[i] = 0;
            e_wa[i] = SCRATCH; e_wd[i] = 16'h0; e_ra[i] = 16'h0; e_rv[i] = 16'h0;
        end
        a_req = 1'b0; b_req = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_rdata = 16'h0000; free_at = 0; wcnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            s = k % 4;
            n_tests++;
            if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== {e_ag[s], e_bg[s], e_ar[s], e_br[s]}) begin
                n_fail++;
                $display("FAIL rand_flags cyc %0d: got %b want %b", k,
                         {a_gnt, b_gnt, a_rvalid, b_rvalid}, {e_ag[s], e_bg[s], e_ar[s], e_br[s]});
            end
            exp_rd = (e_ar[s] || e_br[s]) ? e_rv[s] : m_rdata;
            m_rdata = exp_rd;
            n_tests++;
            if (rdata !== exp_rd) begin
                n_fail++; $display("FAIL rand_rdata cyc %0d: got %h want %h", k, rdata, exp_rd);
            end
            n_tests++;
            if (mem_write_addr !== e_wa[s] || mem_write_data !== e_wd[s]) begin
                n_fail++;
                $display("FAIL rand_wpath cyc %0d: got %h/%h want %h/%h", k, mem_write_addr, mem_write_data, e_wa[s], e_wd[s]);
            end
            if (e_ron[s]) begin
                n_tests++;
                if (mem_read_addr !== e_ra[s]) begin
                    n_fail++; $display("FAIL rand_raddr cyc %0d: got %h want %h", k, mem_read_addr, e_ra[s]);
                end
            end
            if (e_ag[s]) a_req = 1'b0;
            if (e_bg[s]) b_req = 1'b0;
            if (!a_req && !e_ag[s] && $urandom_range(2) == 0) begin
                a_req = 1'b1; a_we = 1'($urandom); a_addr = 16'($urandom); a_wdata = 16'($urandom);
            end
            if (!b_req && !e_bg[s] && $urandom_range(2) == 0) begin
                b_req = 1'b1; b_we = 1'($urandom); b_addr = 16'($urandom); b_wdata = 16'($urandom);
            end
            e_ag[s] = 0; e_bg[s] = 0; e_ar[s] = 0; e_br[s] = 0; e_ron[s] = 0;
            e_wa[s] = SCRATCH; e_wd[s] = 16'h0;
            if (k >= free_at) begin
                pick_a = a_req && !(b_req && wcnt == MAXW);
                pick_b = !pick_a && b_req;
                if (pick_b || !b_req) wcnt = 0;
                else if (wcnt < MAXW) wcnt = wcnt + 1;
                if (pick_a || pick_b) begin
                    we   = pick_b ? b_we : a_we;
                    addr = pick_b ? b_addr : a_addr;
                    wd   = pick_b ? b_wdata : a_wdata;
                    t = (k + 1) % 4;
                    e_ag[t] = pick_a; e_bg[t] = pick_b;
                    e_ron[t] = 1'b1; e_ra[t] = addr;
                    if (we) begin
                        if (addr[3:0] != SCRATCH[3:0]) begin
                            rm[addr[3:0]] = wd; e_wa[t] = addr; e_wd[t] = wd;
                        end
                        free_at = k + 2;
                    end else begin
                        r = (k + 2) % 4;
                        e_ar[r] = pick_a; e_br[r] = pick_b;
                        e_rv[r] = rm[addr[3:0]];
                        free_at = k + 3;
                    end
                end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_scratch();
        test_reset_in_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
